// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - single-port register unit bus between alu_sequencer and the 16x8 register file
interface alu_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) ();
    logic [ADDR_W-1:0] rf_addr;
    logic              rf_load;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rf_rdata;

    modport master (output rf_addr, output rf_load, output rf_wdata, input rf_rdata);
    modport slave  (input rf_addr, input rf_load, input rf_wdata, output rf_rdata);
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - one register-to-register ALU op per start: read A, read B, execute, write back
// Optional feature macro ALU_SEQ_SHIFT_EN: enables SHL/SHR on opcodes 6/7 (illegal otherwise).
module alu_sequencer #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int READ_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero,
    alu_sequencer_if.master   rf
);
    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(READ_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_RDA, S_RDB, S_EXEC, S_WB, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        opcode_q;
    logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, result_q;
    logic              carry_q, zero_q, busy_q;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry, illegal_op, last_rd;

    assign last_rd = (cnt_q == LAST_CNT);

    always_comb begin
        alu_res    = '0;
        alu_carry  = 1'b0;
        illegal_op = 1'b0;
        case (opcode_q)
            3'd0: {alu_carry, alu_res} = {1'b0, op_a_q} + {1'b0, op_b_q};
            3'd1: begin
                alu_res   = op_a_q - op_b_q;
                alu_carry = (op_a_q < op_b_q);
            end
            3'd2: alu_res = op_a_q & op_b_q;
            3'd3: alu_res = op_a_q | op_b_q;
            3'd4: alu_res = op_a_q ^ op_b_q;
            3'd5: alu_res = op_a_q;
`ifdef ALU_SEQ_SHIFT_EN
            3'd6: alu_res = {op_a_q[DATA_W-2:0], 1'b0};
            3'd7: alu_res = {1'b0, op_a_q[DATA_W-1:1]};
`endif
            default: illegal_op = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rf.rf_addr  = '0;
        rf.rf_load  = 1'b0;
        rf.rf_wdata = '0;
        case (state_q)
            S_IDLE: if (start) state_d = S_RDA;
            S_RDA: begin
                rf.rf_addr = src_a_q;
                if (last_rd) begin
                    cnt_d   = '0;
                    state_d = S_RDB;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RDB: begin
                rf.rf_addr = src_b_q;
                if (last_rd) begin
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EXEC: state_d = S_WB;
            S_WB: begin
                // Illegal ops still pass through WB so latency is identical, but never write.
                rf.rf_addr  = dst_q;
                rf.rf_wdata = result_q;
                rf.rf_load  = !illegal_op;
                state_d     = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            opcode_q <= '0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && start) begin
                opcode_q <= opcode;
                src_a_q  <= src_a;
                src_b_q  <= src_b;
                dst_q    <= dst;
                busy_q   <= 1'b1;
            end
            if (state_q == S_DONE) busy_q <= 1'b0;
            if (state_q == S_RDA && last_rd) op_a_q <= rf.rf_rdata;
            if (state_q == S_RDB && last_rd) op_b_q <= rf.rf_rdata;
            if (state_q == S_EXEC && !illegal_op) begin
                result_q <= alu_res;
                carry_q  <= alu_carry;
                zero_q   <= (alu_res == '0);
            end
        end
    end

    assign busy   = busy_q;
    assign done   = (state_q == S_DONE);
    assign err    = (state_q == S_DONE) && illegal_op;
    assign result = result_q;
    assign carry  = carry_q;
    assign zero   = zero_q;
endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer (READ_LAT=2 and READ_LAT=1 instances)
module tb_alu_sequencer;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [2:0] opcode = '0;
    logic [3:0] src_a = '0, src_b = '0, dst = '0;
    logic       busy, done, err, carry, zero;
    logic [7:0] result;

    logic       start2 = 1'b0;
    logic [2:0] opcode2 = '0;
    logic [3:0] src_a2 = '0, src_b2 = '0, dst2 = '0;
    logic       busy2, done2, err2, carry2, zero2;
    logic [7:0] result2;

    logic [7:0] mem  [16];
    logic [7:0] mem2 [16];
    logic [7:0] rdata_q;
    logic       do_preload = 1'b0;
    int         wr_count = 0, wr_count2 = 0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;

    int n_checks = 0;
    int n_fail   = 0;

    alu_sequencer_if #(.DATA_W(8), .ADDR_W(4)) rf  ();
    alu_sequencer_if #(.DATA_W(8), .ADDR_W(4)) rf2 ();

    alu_sequencer #(.DATA_W(8), .ADDR_W(4), .READ_LAT(2)) dut (
        .clock(clock), .reset(reset), .start(start), .opcode(opcode),
        .src_a(src_a), .src_b(src_b), .dst(dst), .busy(busy), .done(done),
        .err(err), .result(result), .carry(carry), .zero(zero), .rf(rf)
    );

    alu_sequencer #(.DATA_W(8), .ADDR_W(4), .READ_LAT(1)) dut_lat1 (
        .clock(clock), .reset(reset), .start(start2), .opcode(opcode2),
        .src_a(src_a2), .src_b(src_b2), .dst(dst2), .busy(busy2), .done(done2),
        .err(err2), .result(result2), .carry(carry2), .zero(zero2), .rf(rf2)
    );

    always #5 clock = ~clock;

    // Register unit models: registered read for READ_LAT=2, combinational read for READ_LAT=1.
    always @(posedge clock) rdata_q <= mem[rf.rf_addr];
    assign rf.rf_rdata  = rdata_q;
    assign rf2.rf_rdata = mem2[rf2.rf_addr];

    always @(posedge clock) begin
        if (do_preload) begin
            for (int i = 0; i < 16; i++) begin
                mem[i]  <= 8'h00;
                mem2[i] <= 8'h00;
            end
            mem[1]  <= 8'h0F; mem[2]  <= 8'hF1; mem[3]  <= 8'h80; mem[4]  <= 8'h0F; mem[7]  <= 8'h55;
            mem2[1] <= 8'h0F; mem2[2] <= 8'hF1; mem2[3] <= 8'h80; mem2[4] <= 8'h0F; mem2[7] <= 8'h55;
        end else begin
            if (rf.rf_load) begin
                mem[rf.rf_addr] <= rf.rf_wdata;
                wr_count = wr_count + 1;
                wr_addr  = rf.rf_addr;
                wr_data  = rf.rf_wdata;
            end
            if (rf2.rf_load) begin
                mem2[rf2.rf_addr] <= rf2.rf_wdata;
                wr_count2 = wr_count2 + 1;
            end
        end
    end

    task automatic preload();
        @(negedge clock); do_preload = 1'b1;
        @(negedge clock); do_preload = 1'b0;
    endtask

    // Issues one op on the READ_LAT=2 instance; returns at the negedge where done is seen.
    // lat counts rising edges from the accept edge (inclusive); 40 means done never came.
    task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] d, output int lat);
        @(negedge clock);
        start = 1'b1; opcode = op; src_a = a; src_b = b; dst = d;
        @(posedge clock);
        lat = 1;
        #1 start = 1'b0; opcode = ~op; src_a = ~a; src_b = ~b; dst = ~d;
        while (lat < 40) begin
            @(negedge clock);
            if (done === 1'b1) break;
            @(posedge clock);
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if ({busy, done, err, result, carry, zero} !== 12'h000) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 000", {busy, done, err, result, carry, zero});
        end
        n_checks++;
        if ({rf.rf_addr, rf.rf_load, rf.rf_wdata} !== 13'h0) begin
            n_fail++; $display("FAIL reset_rf_bus: got %h expected 0", {rf.rf_addr, rf.rf_load, rf.rf_wdata});
        end
        start = 1'b0;
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_add();
        int lat, w0;
        preload();
        w0 = wr_count;
        run_op(3'd0, 4'd1, 4'd2, 4'd5, lat);
        n_checks++;
        if (lat !== 7) begin n_fail++; $display("FAIL add_latency: got %0d expected 7", lat); end
        n_checks++;
        if ({result, carry, zero, err, busy} !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL add_result: got res=%h c=%b z=%b e=%b busy=%b expected res=00 c=1 z=1 e=0 busy=1",
                               result, carry, zero, err, busy);
        end
        n_checks++;
        if ({wr_count - w0, wr_addr, wr_data} !== {32'd1, 4'd5, 8'h00}) begin
            n_fail++; $display("FAIL add_writeback: got n=%0d addr=%0d data=%h expected n=1 addr=5 data=00",
                               wr_count - w0, wr_addr, wr_data);
        end
        @(negedge clock);
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL add_busy_drop: got %b expected 00", {busy, done}); end
    endtask

    task automatic test_sub_xor();
        int lat;
        preload();
        run_op(3'd1, 4'd1, 4'd2, 4'd1, lat);
        n_checks++;
        if ({result, carry, zero} !== {8'h1E, 1'b1, 1'b0} || mem[1] !== 8'h1E) begin
            n_fail++; $display("FAIL sub_result: got res=%h c=%b z=%b r1=%h expected res=1e c=1 z=0 r1=1e",
                               result, carry, zero, mem[1]);
        end
        run_op(3'd4, 4'd1, 4'd1, 4'd9, lat);
        n_checks++;
        if ({result, carry, zero, lat} !== {8'h00, 1'b0, 1'b1, 32'd7}) begin
            n_fail++; $display("FAIL xor_same_reg: got res=%h c=%b z=%b lat=%0d expected res=00 c=0 z=1 lat=7",
                               result, carry, zero, lat);
        end
    endtask

    task automatic test_busy_ignore();
        int w0, dcount;
        preload();
        w0 = wr_count; dcount = 0;
        @(negedge clock); start = 1'b1; opcode = 3'd2; src_a = 4'd1; src_b = 4'd4; dst = 4'd10;
        @(posedge clock); #1 start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done === 1'b1) dcount++;
            start = (i == 1 || i == 3 || i == 5);
        end
        n_checks++;
        if (dcount !== 1 || wr_count - w0 !== 1) begin
            n_fail++; $display("FAIL busy_ignore_count: got done=%0d writes=%0d expected 1 and 1", dcount, wr_count - w0);
        end
        n_checks++;
        if (result !== 8'h0F || mem[10] !== 8'h0F) begin
            n_fail++; $display("FAIL busy_ignore_result: got res=%h r10=%h expected 0f 0f", result, mem[10]);
        end
    endtask

    task automatic test_shift();
        int lat, w0;
        preload();
        run_op(3'd1, 4'd1, 4'd2, 4'd9, lat);
        w0 = wr_count;
        run_op(3'd6, 4'd3, 4'd0, 4'd6, lat);
`ifdef ALU_SEQ_SHIFT_EN
        n_checks++;
        if ({result, carry, zero, err, lat} !== {8'h00, 1'b0, 1'b1, 1'b0, 32'd7} || mem[6] !== 8'h00 || wr_count - w0 !== 1) begin
            n_fail++; $display("FAIL shl: got res=%h c=%b z=%b e=%b lat=%0d r6=%h n=%0d expected 00 0 1 0 7 00 1",
                               result, carry, zero, err, lat, mem[6], wr_count - w0);
        end
        run_op(3'd7, 4'd2, 4'd0, 4'd6, lat);
        n_checks++;
        if ({result, carry, zero, err} !== {8'h78, 1'b0, 1'b0, 1'b0} || mem[6] !== 8'h78) begin
            n_fail++; $display("FAIL shr: got res=%h c=%b z=%b e=%b r6=%h expected 78 0 0 0 78",
                               result, carry, zero, err, mem[6]);
        end
`else
        n_checks++;
        if ({result, carry, zero, err, done, lat} !== {8'h1E, 1'b1, 1'b0, 1'b1, 1'b1, 32'd7} || wr_count - w0 !== 0) begin
            n_fail++; $display("FAIL shl_illegal: got res=%h c=%b z=%b e=%b d=%b lat=%0d n=%0d expected 1e 1 0 1 1 7 0",
                               result, carry, zero, err, done, lat, wr_count - w0);
        end
        run_op(3'd7, 4'd2, 4'd0, 4'd6, lat);
        n_checks++;
        if ({result, carry, err} !== {8'h1E, 1'b1, 1'b1} || wr_count - w0 !== 0 || mem[6] !== 8'h00) begin
            n_fail++; $display("FAIL shr_illegal: got res=%h c=%b e=%b n=%0d r6=%h expected 1e 1 1 0 00",
                               result, carry, err, wr_count - w0, mem[6]);
        end
`endif
        @(negedge clock);
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_width: got %b expected 0", err); end
    endtask

    task automatic test_reset_in_wb();
        int lat, w0, n;
        preload();
        w0 = wr_count; n = 0;
        @(negedge clock); start = 1'b1; opcode = 3'd5; src_a = 4'd2; src_b = 4'd0; dst = 4'd7;
        @(posedge clock); #1 start = 1'b0;
        while (n < 20) begin
            @(negedge clock);
            if (rf.rf_load === 1'b1) break;
            n++;
        end
        n_checks++;
        if (n !== 5) begin n_fail++; $display("FAIL reset_wb_reach: got %0d cycles expected 5", n); end
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rf.rf_load, rf.rf_addr, busy, done, err, result, carry, zero} !== 17'h0) begin
            n_fail++; $display("FAIL reset_wb_outputs: load=%b addr=%h busy=%b res=%h c=%b z=%b expected all 0",
                               rf.rf_load, rf.rf_addr, busy, result, carry, zero);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (mem[7] !== 8'h55 || wr_count - w0 !== 0) begin
            n_fail++; $display("FAIL reset_wb_nowrite: got r7=%h n=%0d expected 55 0", mem[7], wr_count - w0);
        end
        run_op(3'd5, 4'd2, 4'd0, 4'd7, lat);
        n_checks++;
        if (result !== 8'hF1 || mem[7] !== 8'hF1 || lat !== 7) begin
            n_fail++; $display("FAIL reset_wb_recover: got res=%h r7=%h lat=%0d expected f1 f1 7", result, mem[7], lat);
        end
    endtask

    task automatic test_back_to_back();
        int w0, first, second;
        preload();
        w0 = wr_count; first = -1; second = -1;
        @(negedge clock); start = 1'b1; opcode = 3'd3; src_a = 4'd1; src_b = 4'd2; dst = 4'd12;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                if (first < 0) first = c;
                else begin second = c; break; end
            end
        end
        start = 1'b0;
        repeat (4) @(negedge clock);
        n_checks++;
        if (second - first !== 8 || first < 0) begin
            n_fail++; $display("FAIL b2b_rate: got spacing %0d (first=%0d) expected 8", second - first, first);
        end
        n_checks++;
        if (wr_count - w0 !== 2 || result !== 8'hFF || mem[12] !== 8'hFF || busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_result: got n=%0d res=%h r12=%h busy=%b expected 2 ff ff 0",
                               wr_count - w0, result, mem[12], busy);
        end
    endtask

    task automatic test_read_lat1();
        int lat, w0;
        preload();
        w0 = wr_count2;
        @(negedge clock); start2 = 1'b1; opcode2 = 3'd3; src_a2 = 4'd1; src_b2 = 4'd2; dst2 = 4'd8;
        @(posedge clock); lat = 1;
        #1 start2 = 1'b0; opcode2 = 3'd0;
        while (lat < 40) begin
            @(negedge clock);
            if (done2 === 1'b1) break;
            @(posedge clock);
            lat++;
        end
        n_checks++;
        if (lat !== 5) begin n_fail++; $display("FAIL lat1_latency: got %0d expected 5", lat); end
        n_checks++;
        if ({result2, zero2, carry2, err2} !== {8'hFF, 1'b0, 1'b0, 1'b0} || mem2[8] !== 8'hFF || wr_count2 - w0 !== 1) begin
            n_fail++; $display("FAIL lat1_result: got res=%h z=%b c=%b e=%b r8=%h n=%0d expected ff 0 0 0 ff 1",
                               result2, zero2, carry2, err2, mem2[8], wr_count2 - w0);
        end
        @(negedge clock);
        n_checks++;
        if (busy2 !== 1'b0) begin n_fail++; $display("FAIL lat1_busy: got %b expected 0", busy2); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_xor();
        test_busy_ignore();
        test_shift();
        test_reset_in_wb();
        test_back_to_back();
        test_read_lat1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule
